// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//
// Purpose:
//   ALU-side consumer of the decode-to-ALU control interface. It registers the
//   per-cycle control into the execute stage and tracks multi-cycle
//   instruction sequences. For iterative datapaths such as divide, it produces
//   start, busy and done strobes and a cycle index. It also watches the decode
//   side for multi-cycle protocol violations and latches the first one in a
//   sticky flag for debug.
//
// Handshake / protocol (decode -> ALU):
//   An op is presented for one cycle with en=1 and multi_cycle=0. That cycle is
//   the op's first cycle. A multi-cycle op continues on the following cycles
//   with multi_cycle=1, and its final cycle also carries last_cycle=1. There is
//   no ready/back-pressure path to decode. Instead, stall=1 freezes every
//   register in this block, including the strobes, so that the strobes stay
//   aligned with the frozen pipeline. Only accepted cycles (stall=0) advance
//   the sequence. err_clear is honoured on every edge, stalled or not.
//
// Ports:
//   clk          in   1      clock, all state on rising edge
//   reset        in   1      asynchronous active-low reset
//   en           in   1      ALU op valid this cycle
//   multi_cycle  in   1      high from second cycle of a multi-cycle op
//   last_cycle   in   1      high on final cycle of a multi-cycle op
//   stall        in   1      pipeline stall; freezes this block
//   fwd_from_alu in   1      operand forwarded from ALU result
//   fwd_from_ls  in   1      operand forwarded from load/store
//   rot_dist     in   5      rotate distance
//   err_clear    in   1      clears sticky error
//   ex_start     out  1      first cycle of an accepted op
//   ex_busy      out  1      multi-cycle op in progress
//   ex_done      out  1      last cycle of a multi-cycle op
//   ex_cycle     out  CNT_W  cycle index within current op, 0 = first
//   opa_sel      out  2      00 register file, 01 ALU forward, 10 LS forward
//   rot_dist_q   out  5      registered rotate distance
//   proto_err    out  1      sticky protocol-violation flag
//   err_code     out  2      first error cause: 01 orphan, 10 abandon, 11 overflow
//   dbg_state    out  2      FSM state for debug: 0 IDLE, 1 FIRST, 2 MULTI
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int CNT_W      = 6,
    parameter int MAX_CYCLES = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             multi_cycle,
    input  logic             last_cycle,
    input  logic             stall,
    input  logic             fwd_from_alu,
    input  logic             fwd_from_ls,
    input  logic [4:0]       rot_dist,
    input  logic             err_clear,
    output logic             ex_start,
    output logic             ex_busy,
    output logic             ex_done,
    output logic [CNT_W-1:0] ex_cycle,
    output logic [1:0]       opa_sel,
    output logic [4:0]       rot_dist_q,
    output logic             proto_err,
    output logic [1:0]       err_code,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_MULTI = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ORPHAN   = 2'b01;
    localparam logic [1:0] ERR_ABANDON  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    localparam logic [1:0] OPA_RF  = 2'b00;
    localparam logic [1:0] OPA_ALU = 2'b01;
    localparam logic [1:0] OPA_LS  = 2'b10;

    // Highest cycle index an op may reach.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_CYCLES - 1);

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [1:0]         opa_q, opa_d;
    logic [4:0]         rot_q, rot_d;
    logic               perr_q, perr_d;
    logic [1:0]         code_q, code_d;

    logic               new_err;
    logic [1:0]         new_code;
    logic [CNT_W-1:0]   cycle_inc;

    assign cycle_inc = cycle_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cycle_q <= '0;
            opa_q   <= OPA_RF;
            rot_q   <= 5'd0;
            perr_q  <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cycle_q <= cycle_d;
            opa_q   <= opa_d;
            rot_q   <= rot_d;
            perr_q  <= perr_d;
            code_q  <= code_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // A stalled edge holds everything by default.
        state_d  = state_q;
        start_d  = start_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cycle_d  = cycle_q;
        opa_d    = opa_q;
        rot_d    = rot_q;
        new_err  = 1'b0;
        new_code = ERR_NONE;

        if (!stall) begin
            if (fwd_from_alu) begin
                opa_d = OPA_ALU;        // ALU forward has priority over LS
            end else if (fwd_from_ls) begin
                opa_d = OPA_LS;
            end else begin
                opa_d = OPA_RF;
            end
            rot_d = rot_dist;

            // On an accepted cycle every strobe is recomputed from zero.
            start_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cycle_d = '0;
            state_d = S_IDLE;

            if (en && !multi_cycle) begin
                // New op. Arriving while a multi-cycle op is still open means
                // that the open op was abandoned.
                start_d = 1'b1;
                state_d = S_FIRST;
                if (state_q == S_MULTI) begin
                    new_err  = 1'b1;
                    new_code = ERR_ABANDON;
                end
            end else if (multi_cycle) begin
                if (state_q == S_IDLE) begin
                    // Continuation with no op open: report it and stay idle.
                    new_err  = 1'b1;
                    new_code = ERR_ORPHAN;
                end else begin
                    cycle_d = cycle_inc;
                    if (last_cycle) begin
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (state_q == S_MULTI && cycle_inc == LAST_IDX) begin
                        // The op reached its maximum length without
                        // last_cycle. Stop counting and drop the op.
                        new_err  = 1'b1;
                        new_code = ERR_OVERFLOW;
                        state_d  = S_IDLE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_MULTI;
                    end
                end
            end else if (state_q == S_MULTI) begin
                // The op went quiet before last_cycle arrived.
                new_err  = 1'b1;
                new_code = ERR_ABANDON;
            end
            // en=0, multi_cycle=0 from FIRST or IDLE: the op was single-cycle,
            // or there was no op. Go to IDLE with no error.
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error capture. err_clear applies first, so an error on the same
    // edge still gets recorded.
    // -------------------------------------------------------------------------
    always_comb begin
        perr_d = perr_q;
        code_d = code_q;
        if (err_clear) begin
            perr_d = 1'b0;
            code_d = ERR_NONE;
        end
        if (new_err && !perr_d) begin
            perr_d = 1'b1;
            code_d = new_code;
        end
    end

    assign ex_start   = start_q;
    assign ex_busy    = busy_q;
    assign ex_done    = done_q;
    assign ex_cycle   = cycle_q;
    assign opa_sel    = opa_q;
    assign rot_dist_q = rot_q;
    assign proto_err  = perr_q;
    assign err_code   = code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  localparam int CNT_W = 6;
  localparam int MAX_CYCLES = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic en = 0, multi_cycle = 0, last_cycle = 0, stall = 0;
  logic fwd_from_alu = 0, fwd_from_ls = 0, err_clear = 0;
  logic [4:0] rot_dist = 5'd0;

  logic ex_start, ex_busy, ex_done, proto_err;
  logic [CNT_W-1:0] ex_cycle;
  logic [1:0] opa_sel, err_code, dbg_state;
  logic [4:0] rot_dist_q;

  alu_ctrl_seq #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .reset(reset), .en(en), .multi_cycle(multi_cycle),
    .last_cycle(last_cycle), .stall(stall), .fwd_from_alu(fwd_from_alu),
    .fwd_from_ls(fwd_from_ls), .rot_dist(rot_dist), .err_clear(err_clear),
    .ex_start(ex_start), .ex_busy(ex_busy), .ex_done(ex_done),
    .ex_cycle(ex_cycle), .opa_sel(opa_sel), .rot_dist_q(rot_dist_q),
    .proto_err(proto_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // strobes packed as {start,busy,done}
  task automatic check_seq(input string tag, input int strb, input int cyc, input int st);
    check({tag, ".strb"}, int'({ex_start, ex_busy, ex_done}), strb);
    check({tag, ".cyc"}, int'(ex_cycle), cyc);
    check({tag, ".st"}, int'(dbg_state), st);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge. Outputs are sampled then too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic m, input logic l);
    en = e; multi_cycle = m; last_cycle = l;
  endtask

  int max_cyc;

  initial begin
    // ---- reset ----
    #1;
    check_seq("rst", 0, 0, 0);
    check("rst.perr", int'(proto_err), 0);
    check("rst.code", int'(err_code), 0);
    check("rst.opa", int'(opa_sel), 0);
    step(); step();
    reset = 1'b1;

    // ---- single-cycle op, plus stall holding ex_start ----
    drive(1, 0, 0); step();
    check_seq("sc.t0", 3'b100, 0, 1);
    drive(0, 0, 0); step();
    check_seq("sc.t1", 0, 0, 0);
    check("sc.perr", int'(proto_err), 0);
    drive(1, 0, 0); step();
    stall = 1; drive(0, 0, 0); step();
    check_seq("sc.stall", 3'b100, 0, 1);
    stall = 0; step();
    check_seq("sc.rel", 0, 0, 0);

    // ---- 4-cycle op ----
    drive(1, 0, 0); step(); check_seq("m4.c0", 3'b100, 0, 1);
    drive(0, 1, 0); step(); check_seq("m4.c1", 3'b010, 1, 2);
    step();                 check_seq("m4.c2", 3'b010, 2, 2);
    drive(0, 1, 1); step(); check_seq("m4.c3", 3'b011, 3, 0);
    drive(0, 0, 0); step(); check_seq("m4.end", 0, 0, 0);
    check("m4.perr", int'(proto_err), 0);

    // ---- 4-cycle op with 2 stall cycles at ex_cycle=1 ----
    drive(1, 0, 0); step(); check_seq("ms.c0", 3'b100, 0, 1);
    drive(0, 1, 0); step(); check_seq("ms.c1", 3'b010, 1, 2);
    stall = 1;      step(); check_seq("ms.s1", 3'b010, 1, 2);
                    step(); check_seq("ms.s2", 3'b010, 1, 2);
    stall = 0;      step(); check_seq("ms.c2", 3'b010, 2, 2);
    drive(0, 1, 1); step(); check_seq("ms.c3", 3'b011, 3, 0);
    drive(0, 0, 0); step(); check_seq("ms.end", 0, 0, 0);

    // ---- orphan, then abandon: first code is kept ----
    drive(0, 1, 0); step();
    check_seq("or", 0, 0, 0);
    check("or.perr", int'(proto_err), 1);
    check("or.code", int'(err_code), 1);
    drive(1, 0, 0); step();
    drive(0, 1, 0); step(); check_seq("ab.c1", 3'b010, 1, 2);
    drive(1, 0, 0); step();
    check_seq("ab.restart", 3'b100, 0, 1);
    check("ab.perr", int'(proto_err), 1);
    check("ab.code", int'(err_code), 1);
    drive(0, 0, 0); step();
    // clear during a stall
    stall = 1; err_clear = 1; step();
    err_clear = 0; stall = 0;
    check("clr.perr", int'(proto_err), 0);
    check("clr.code", int'(err_code), 0);

    // ---- the error wins over err_clear on the same edge ----
    drive(0, 1, 0); step();
    check("or2.code", int'(err_code), 1);
    drive(1, 0, 0); step();
    drive(0, 1, 0); step();
    drive(0, 0, 0); err_clear = 1; step();
    err_clear = 0;
    check("ab2.st", int'(dbg_state), 0);
    check("ab2.perr", int'(proto_err), 1);
    check("ab2.code", int'(err_code), 2);
    err_clear = 1; step(); err_clear = 0;
    check("clr2.perr", int'(proto_err), 0);

    // ---- overflow: multi_cycle without last_cycle for 40 cycles ----
    drive(1, 0, 0); step();
    drive(0, 1, 0);
    max_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (int'(ex_cycle) > max_cyc) max_cyc = int'(ex_cycle);
      if (k == 32) check_seq("ov.k32", 3'b010, 32, 2);
      if (k == 33) begin
        check_seq("ov.k33", 0, 33, 0);
        check("ov.code", int'(err_code), 3);
      end
    end
    check("ov.max", max_cyc, 33);
    check("ov.busy", int'(ex_busy), 0);
    check("ov.code_end", int'(err_code), 3);
    drive(0, 0, 0); err_clear = 1; step(); err_clear = 0;
    check("ov.clr", int'(proto_err), 0);

    // ---- asynchronous reset in the middle of an op ----
    rot_dist = 5'd19; fwd_from_ls = 1;
    drive(1, 0, 0); step();
    drive(0, 1, 0); step(); step();
    check_seq("rm.c2", 3'b010, 2, 2);
    check("rm.rot", int'(rot_dist_q), 19);
    reset = 1'b0; #1;
    check_seq("rm.rst", 0, 0, 0);
    check("rm.opa", int'(opa_sel), 0);
    check("rm.rot0", int'(rot_dist_q), 0);
    step();
    check("rm.nodone", int'(ex_done), 0);
    reset = 1'b1;
    drive(0, 0, 0);

    // ---- forwarding select and rotate distance ----
    fwd_from_alu = 1; fwd_from_ls = 1; rot_dist = 5'd7; step();
    check("fw.both", int'(opa_sel), 1);
    check("fw.rot7", int'(rot_dist_q), 7);
    fwd_from_alu = 0; fwd_from_ls = 1; rot_dist = 5'd31; step();
    check("fw.ls", int'(opa_sel), 2);
    check("fw.rot31", int'(rot_dist_q), 31);
    fwd_from_alu = 1; fwd_from_ls = 0; step();
    check("fw.alu", int'(opa_sel), 1);
    fwd_from_alu = 0; fwd_from_ls = 0; stall = 1; rot_dist = 5'd2; step();
    check("fw.stall", int'(opa_sel), 1);
    check("fw.stallrot", int'(rot_dist_q), 31);
    stall = 0; step();
    check("fw.rf", int'(opa_sel), 0);
    check("fw.rot2", int'(rot_dist_q), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- ALU-side consumer of the decode-to-ALU control interface.
- Registers the per-cycle control (en, multi_cycle, last_cycle, stall, forwarding flags, rotate distance) into the execute stage.
- Tracks multi-cycle instruction sequences and generates start, busy and done strobes plus a cycle index for iterative datapaths such as divide.
- Checks that the decode side obeys the multi-cycle protocol and flags violations for debug.

Parameters:
- CNT_W, 6, width of the cycle index counter.
- MAX_CYCLES, 34, maximum legal cycles of one multi-cycle op including the first; must be <= 2**CNT_W.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-low reset
- en  in  1  ALU op valid this cycle
- multi_cycle  in  1  high from second cycle of a multi-cycle op
- last_cycle  in  1  high on final cycle of a multi-cycle op
- stall  in  1  pipeline stall; freezes this block
- fwd_from_alu  in  1  operand forwarded from ALU result
- fwd_from_ls  in  1  operand forwarded from load/store
- rot_dist  in  5  rotate distance
- err_clear  in  1  clears sticky error
- ex_start  out  1  first cycle of an accepted op
- ex_busy  out  1  multi-cycle op in progress
- ex_done  out  1  last cycle of a multi-cycle op
- ex_cycle  out  CNT_W  cycle index within current op, 0 = first
- opa_sel  out  2  00 register file, 01 ALU forward, 10 LS forward
- rot_dist_q  out  5  registered rotate distance
- proto_err  out  1  sticky protocol-violation flag
- err_code  out  2  cause of first error: 01 orphan multi, 10 abandon, 11 overflow

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including proto_err and err_code.
  - Reset mid-sequence aborts the op silently; no ex_done is produced.
- Accepted cycle: any rising edge with stall=0.
  - With stall=1, every register holds its value, including ex_start and ex_done.
  - This means a strobe stays high for the whole stall, matching the frozen pipeline.
- opa_sel and rot_dist_q are registered on every accepted cycle.
  - opa_sel = 01 if fwd_from_alu, else 10 if fwd_from_ls, else 00.
  - ALU forwarding has priority over LS forwarding.
- States are IDLE, FIRST and MULTI. On each accepted cycle:
  - en=1, multi_cycle=0, from any state:
    - ex_start=1, ex_cycle=0, ex_done=0, ex_busy=0; next state FIRST.
    - If the old state was MULTI, this is an abandon error.
  - multi_cycle=1 in FIRST or MULTI:
    - ex_start=0, ex_busy=1, ex_cycle=ex_cycle+1.
    - If last_cycle=1: ex_done=1, next state IDLE.
    - Otherwise: ex_done=0, next state MULTI.
  - multi_cycle=1 in IDLE (orphan multi): error 01; ex_busy=0, ex_done=0, ex_cycle=0; stay IDLE.
  - en=0 and multi_cycle=0:
    - From FIRST: the previous op was single-cycle; go to IDLE with no error.
    - From MULTI: abandon error 10; go to IDLE.
    - In both cases all strobes are 0 and ex_cycle=0.
  - last_cycle=1 with multi_cycle=0 is ignored, because the protocol only defines last_cycle together with multi_cycle.
  - Overflow: in MULTI, multi_cycle=1, last_cycle=0 and ex_cycle+1 == MAX_CYCLES-1.
    - Raises error 11, forces IDLE and sets ex_busy=0.
    - ex_cycle is never incremented past MAX_CYCLES-1.
- Error capture:
  - proto_err is set on the first error. err_code records that error's cause and is not overwritten by later errors while proto_err=1.
  - err_clear=1 on an accepted or stalled edge clears both proto_err and err_code.
  - If err_clear and a new error fall on the same edge, the new error wins.
- Latency: all outputs are registered, with exactly one cycle from input to output.

Test Plan:
- Reset then single-cycle op: en=1 for 1 cycle, then en=0.
  - Expect ex_start=1 one cycle later, ex_cycle=0, then all strobes 0 and proto_err=0.
- 4-cycle op: en=1; then multi_cycle=1 for 3 cycles, last_cycle=1 on the third.
  - Expect ex_cycle = 0,1,2,3; ex_busy=1 on cycles 1-3; ex_done=1 only at ex_cycle=3; state back to IDLE.
- Same 4-cycle op with stall=1 for 2 cycles at ex_cycle=1.
  - Expect ex_cycle held at 1 for 3 cycles; completion delayed by 2; ex_done still a single accepted cycle.
- multi_cycle=1 from IDLE, then en=1 multi_cycle=0 mid-MULTI.
  - Expect proto_err=1 with err_code=01, which is retained after the second error.
  - Then pulse err_clear; expect proto_err=0.
- Run multi_cycle=1 without last_cycle for 40 cycles with MAX_CYCLES=34.
  - Expect ex_cycle to stop at 33, err_code=11 and ex_busy=0.
- Assert reset mid-op at ex_cycle=2, plus a forwarding check.
  - Reset: all outputs go to 0 immediately with no ex_done.
  - fwd_from_alu=1 with fwd_from_ls=1 gives opa_sel=01; fwd_from_ls alone gives 10.
